// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, defaults and width helper for the SPI transmit stage
package spi_pkg;

  localparam int SPI_DATA_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // Bits needed to count 0..value-1; never less than 1 so degenerate counters stay legal.
  function automatic int spi_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - SCLK half-period divider with rise/fall strobes
module spi_sclk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);
  import spi_pkg::*;

  localparam int HC_W = spi_clog2(HALF_DIV);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_DIV - 1);

  logic [HC_W-1:0] half_cnt;
  logic            wrap;

  // Strobes mark the cycle whose closing edge toggles sclk.
  assign wrap      = en && (half_cnt == HC_LAST);
  assign sclk_rise = wrap && !sclk;
  assign sclk_fall = wrap && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (!en) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (wrap) begin
      half_cnt <= '0;
      sclk     <= ~sclk;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_tx.sv
// rtl/spi_tx.sv - SPI mode-0 master transmit stage fed by the bus buffer
module spi_tx #(
  parameter int DATA_W   = spi_pkg::SPI_DATA_W,
  parameter int HALF_DIV = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              bus_valid,
  input  logic [DATA_W-1:0] BUS_DATA,
  output logic              spi_ready,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              frame_done
);
  import spi_pkg::*;

  localparam int PH_MAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PH_MAX  = (PH_MAX0 > CS_GAP) ? PH_MAX0 : CS_GAP;
  localparam int PH_W    = spi_clog2(PH_MAX + 1);
  localparam int BC_W    = spi_clog2(DATA_W);

  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);
  localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(DATA_W - 1);

  generate
    if (DATA_W < 2 || HALF_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 || CS_GAP < 0) begin : g_bad_param
      $fatal(1, "spi_tx: parameter below its minimum");
    end
  endgenerate

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              last_bit_q, last_bit_d;
  logic              ready_q, ready_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              sclk_rise, sclk_fall;

  spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst      (RST),
    .en       (state_q == ST_SHIFT),
    .sclk     (spi_sclk),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    last_bit_d = last_bit_q;
    ready_d    = ready_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_valid) begin
          shreg_d = BUS_DATA;
          mosi_d  = BUS_DATA[DATA_W-1];
          ready_d = 1'b0;
          cs_n_d  = 1'b0;
          phase_d = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          phase_d    = '0;
          bit_cnt_d  = '0;
          last_bit_d = 1'b0;
          state_d    = ST_SHIFT;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        // Decide on the rise whether this is the final bit, act on the following fall.
        if (sclk_rise) last_bit_d = (bit_cnt_q == BIT_LAST);
        if (sclk_fall) begin
          if (last_bit_q) begin
            mosi_d  = 1'b0;
            phase_d = '0;
            state_d = ST_HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
            mosi_d    = shreg_q[DATA_W-2];
          end
        end
      end
      ST_HOLD: begin
        if (phase_q == HOLD_LAST) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          phase_d = '0;
          if (CS_GAP == 0) begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (phase_q == GAP_LAST) begin
          ready_d = 1'b1;
          phase_d = '0;
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      phase_q    <= '0;
      last_bit_q <= 1'b0;
      ready_q    <= 1'b1;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      last_bit_q <= last_bit_d;
      ready_q    <= ready_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
    end
  end

  assign spi_ready  = ready_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_mosi   = mosi_q;
  assign frame_done = done_q;

endmodule
